// File: rtl/active_load_edge_counter.sv
// Synchronises the active-load inverter/XOR outputs and counts their rising edges
// over a programmable gate window, presenting results through a valid/ready handshake.
module active_load_edge_counter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned WIN_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             outpn,
   input  logic             outnn,
   input  logic             outxor,
   input  logic [WIN_W-1:0] cfg_window,
   input  logic             start,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [CNT_W-1:0] cnt_p,
   output logic [CNT_W-1:0] cnt_n,
   output logic [CNT_W-1:0] cnt_x,
   output logic             overflow,
   output logic             lvl_p,
   output logic             lvl_n,
   output logic             lvl_x
);

   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

   state_t           state, state_nxt;
   logic [2:0]       sync_q [SYNC_STAGES];
   logic [2:0]       lvl, prev, rise;
   logic [CNT_W-1:0] cnt_q [3];
   logic [WIN_W-1:0] win;
   logic             ovf;
   logic             start_ok;

   // bit 0 = P side, bit 1 = N side, bit 2 = XOR
   assign lvl      = sync_q[SYNC_STAGES-1];
   assign rise     = lvl & ~prev;
   assign start_ok = (state == IDLE) && start;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev <= '0;
      end else begin
         sync_q[0] <= {outxor, outnn, outpn};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev <= lvl;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = (cfg_window == '0) ? HOLD : COUNT;
         COUNT:   if (win == WIN_W'(1)) state_nxt = HOLD;
         HOLD:    if (result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state == COUNT);
      result_valid = (state == HOLD);
   end

   // Results persist through HOLD and IDLE; only an accepted start clears them.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
         ovf <= 1'b0;
         win <= '0;
      end else if (start_ok) begin
         for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
         ovf <= 1'b0;
         win <= cfg_window;
      end else if (state == COUNT) begin
         win <= win - WIN_W'(1);
         for (int unsigned i = 0; i < 3; i++) begin
            if (rise[i]) begin
               if (cnt_q[i] == '1) ovf <= 1'b1;
               else                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign cnt_p    = cnt_q[0];
   assign cnt_n    = cnt_q[1];
   assign cnt_x    = cnt_q[2];
   assign overflow = ovf;
   assign lvl_p    = lvl[0];
   assign lvl_n    = lvl[1];
   assign lvl_x    = lvl[2];

endmodule

// File: tb/tb_active_load_edge_counter.sv
// Scoreboard bench for active_load_edge_counter: stimulus queues expected results,
// a negedge monitor compares them when the DUT hands a result over.
module tb_active_load_edge_counter;

   localparam int unsigned CW = 4;

   typedef struct packed {
      logic [CW-1:0] p;
      logic [CW-1:0] n;
      logic [CW-1:0] x;
      logic          ov;
   } res_t;

   logic          clk = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          outpn = 1'b0, outnn = 1'b0, outxor = 1'b0;
   logic [15:0]   cfg_window = '0;
   logic          start = 1'b0;
   logic          busy, result_valid;
   logic          result_ready = 1'b1;
   logic [CW-1:0] cnt_p, cnt_n, cnt_x;
   logic          overflow, lvl_p, lvl_n, lvl_x;

   res_t        exp_q[$];
   res_t        mon_e;
   int unsigned passed = 0, total = 0;
   int unsigned cyc = 0;
   int          mode = 0;
   int unsigned bad;

   always #5 clk = ~clk;

   active_load_edge_counter #(.CNT_W(CW), .WIN_W(16), .SYNC_STAGES(2)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
      .outpn(outpn), .outnn(outnn), .outxor(outxor),
      .cfg_window(cfg_window), .start(start),
      .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
      .cnt_p(cnt_p), .cnt_n(cnt_n), .cnt_x(cnt_x), .overflow(overflow),
      .lvl_p(lvl_p), .lvl_n(lvl_n), .lvl_x(lvl_x)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   function automatic res_t mk(input int unsigned p, input int unsigned n,
                               input int unsigned x, input logic ov);
      res_t r;
      r.p  = CW'(p);
      r.n  = CW'(n);
      r.x  = CW'(x);
      r.ov = ov;
      return r;
   endfunction

   // mode 1: outpn square wave period 10, outnn its inverse; mode 2: outxor period 4
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (mode == 1 && cyc % 5 == 0) begin
         outpn = ~outpn;
         outnn = ~outpn;
      end
      if (mode == 2 && cyc % 2 == 0) outxor = ~outxor;
   endtask

   task automatic measure(input int unsigned w, input int inj, input res_t e, input string tag);
      int unsigned nb = 0;
      int unsigned guard = 0;
      int s = 0;
      exp_q.push_back(e);
      cfg_window = 16'(w);
      start = 1'b1;
      step();
      start = 1'b0;
      while (!result_valid && guard < w + 20) begin
         if (busy) nb++;
         step();
         s++;
         guard++;
         if (s == inj) outpn = 1'b1;
      end
      chk({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
      chk({tag, "_busy_cycles"}, nb, w);
      chk({tag, "_busy_in_hold"}, {31'd0, busy}, 32'd0);
      if (result_ready) begin
         step();
         chk({tag, "_back_idle"}, {30'd0, busy, result_valid}, 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (result_valid && result_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("cnt_p", {28'd0, cnt_p}, {28'd0, mon_e.p});
            chk("cnt_n", {28'd0, cnt_n}, {28'd0, mon_e.n});
            chk("cnt_x", {28'd0, cnt_x}, {28'd0, mon_e.x});
            chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ov});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      // reset and idle
      repeat (3) step();
      chk("reset_outputs", {busy, result_valid, overflow, cnt_p, cnt_n, cnt_x, lvl_p, lvl_n, lvl_x}, 32'd0);
      wb_rst_i = 1'b0;
      step();
      chk("idle_outputs", {busy, result_valid, overflow, cnt_p, cnt_n, cnt_x, lvl_p, lvl_n, lvl_x}, 32'd0);
      measure(0, -1, mk(0, 0, 0, 1'b0), "win0");

      // square wave on P/N, XOR static high
      outxor = 1'b1;
      mode = 1;
      repeat (20) step();
      chk("lvl_x_tracks", {31'd0, lvl_x}, 32'd1);
      measure(100, -1, mk(10, 10, 0, 1'b0), "square");

      // XOR fast enough to saturate the 4-bit counter
      mode = 2;
      repeat (10) step();
      measure(100, -1, mk(0, 0, 15, 1'b1), "saturate");

      // consumer stalls in HOLD while start pulses arrive
      mode = 1;
      repeat (10) step();
      result_ready = 1'b0;
      measure(20, -1, mk(2, 2, 0, 1'b0), "stall");
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         cfg_window = 16'd5;
         start = (i % 7 == 0);
         step();
         start = 1'b0;
         if (!result_valid || busy || cnt_p != CW'(2) || cnt_n != CW'(2) || cnt_x != '0) bad++;
      end
      chk("hold_stable", bad, 0);
      result_ready = 1'b1;
      cfg_window = 16'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("handshake_start_ignored", {30'd0, busy, result_valid}, 32'd0);
      chk("retained_cnt_p", {28'd0, cnt_p}, 32'd2);
      measure(0, -1, mk(0, 0, 0, 1'b0), "restart");

      // reset 30 cycles into a 100-cycle window
      cfg_window = 16'd100;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (29) step();
      chk("busy_before_abort", {31'd0, busy}, 32'd1);
      wb_rst_i = 1'b1;
      step();
      wb_rst_i = 1'b0;
      chk("abort_outputs", {busy, result_valid, overflow, cnt_p, cnt_n, cnt_x, lvl_p, lvl_n, lvl_x}, 32'd0);
      mode = 0;
      bad = 0;
      repeat (110) begin
         step();
         if (result_valid || busy) bad++;
      end
      chk("no_result_after_abort", bad, 0);

      // single P edge landing on / just after the final window cycle
      outpn = 1'b0;
      outnn = 1'b0;
      outxor = 1'b0;
      repeat (10) step();
      measure(10, 7, mk(1, 0, 0, 1'b0), "edge_last_cycle");
      outpn = 1'b0;
      repeat (10) step();
      measure(10, 8, mk(0, 0, 0, 1'b0), "edge_too_late");

      repeat (5) step();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
